// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with a registered one-hot grant, a rotating priority pointer
// and an optional hold timeout that revokes a grant nobody acknowledges.
module rr_arbiter_param #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_an,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   ack,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic           timeout
);

   // Counter needs at least one bit even when the timeout is disabled.
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   // Hold count seen during the last permitted granted cycle.
   localparam logic [HW-1:0] HoldLast = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StBusy = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [IDW-1:0] id_q, id_d;
   logic           timeout_q, timeout_d;

   logic           sel_found;
   logic [IDW-1:0] sel_idx;
   logic           rel_ack, rel_drop, rel_exp;

   // Pick the first requester at or after ptr, wrapping past N-1 back to 0.
   always_comb begin
      int j;
      sel_found = 1'b0;
      sel_idx   = '0;
      j         = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         if (!sel_found && req[j]) begin
            sel_found = 1'b1;
            sel_idx   = IDW'(j);
         end
      end
   end

   // Next-state logic: grant from IDLE, release from BUSY on ack, req drop or expiry.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      id_d      = id_q;
      timeout_d = 1'b0;
      rel_ack   = 1'b0;
      rel_drop  = 1'b0;
      rel_exp   = 1'b0;
      case (state_q)
         StIdle: begin
            if (sel_found) begin
               state_d = StBusy;
               grant_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
               id_d    = sel_idx;
               hold_d  = '0;
            end
         end
         StBusy: begin
            rel_ack  = ack[id_q];
            rel_drop = !req[id_q];
            rel_exp  = (MAX_HOLD > 0) && (hold_q == HoldLast);
            if (rel_ack || rel_drop || rel_exp) begin
               state_d   = StIdle;
               grant_d   = '0;
               id_d      = '0;
               hold_d    = '0;
               ptr_d     = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
               // Ack and req drop take precedence, so only a pure expiry pulses timeout.
               timeout_d = !rel_ack && !rel_drop;
            end else if (hold_q != {HW{1'b1}}) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
            id_d    = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_an) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         id_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = (state_q == StBusy);
   assign grant_id    = id_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param (N=4, MAX_HOLD=8); outputs sampled 1ns after each edge.
module tb_rr_arbiter_param;

   logic       clk;
   logic       rst_an;
   logic [3:0] req;
   logic [3:0] ack;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       timeout;

   int tests_run = 0;
   int tests_failed = 0;

   rr_arbiter_param #(
      .N        (4),
      .MAX_HOLD (8),
      .IDW      (2)
   ) dut (
      .clk         (clk),
      .rst_an      (rst_an),
      .req         (req),
      .ack         (ack),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare {grant, grant_valid, grant_id, timeout} against the hand-computed value.
   task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] id,
                      input logic to);
      logic [7:0] obs;
      logic [7:0] expv;
      obs  = {grant, grant_valid, grant_id, timeout};
      expv = {g, |g, id, to};
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed grant=%b gv=%b id=%0d to=%b, expected grant=%b gv=%b id=%0d to=%b",
                tag, obs[7:4], obs[3], obs[2:1], obs[0], expv[7:4], expv[3], expv[2:1],
                expv[0]);
      end
   endtask

   initial begin
      logic [3:0] seq_g [5];
      logic [1:0] seq_id [5];
      seq_g  = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      seq_id = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

      // Reset held two edges with all requests high.
      rst_an = 1'b0;
      req    = 4'b1111;
      ack    = 4'b1111;
      step(); chk("reset_edge1", 4'b0000, 2'd0, 1'b0);
      step(); chk("reset_edge2", 4'b0000, 2'd0, 1'b0);

      // Basic: req=0011 from ptr 0.
      rst_an = 1'b1;
      req    = 4'b0011;
      ack    = 4'b0000;
      step(); chk("basic_grant0", 4'b0001, 2'd0, 1'b0);
      ack = 4'b0001;
      step(); chk("basic_gap", 4'b0000, 2'd0, 1'b0);
      ack = 4'b0000;
      step(); chk("basic_grant1", 4'b0010, 2'd1, 1'b0);
      ack = 4'b0001;
      step(); chk("nonwinner_ack", 4'b0010, 2'd1, 1'b0);
      ack = 4'b0010;
      step(); chk("ack1_release", 4'b0000, 2'd0, 1'b0);
      ack = 4'b0000;

      // Fairness from ptr 2 with everyone requesting, each winner acked at once.
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step(); chk($sformatf("fair_grant%0d", i), seq_g[i], seq_id[i], 1'b0);
         ack = seq_g[i];
         step(); chk($sformatf("fair_gap%0d", i), 4'b0000, 2'd0, 1'b0);
         ack = 4'b0000;
      end

      // Timeout: only requester 2, ptr now 3.
      req = 4'b0100;
      step(); chk("to_cycle1", 4'b0100, 2'd2, 1'b0);
      for (int c = 2; c <= 8; c++) begin
         step(); chk($sformatf("to_cycle%0d", c), 4'b0100, 2'd2, 1'b0);
      end
      step(); chk("to_pulse", 4'b0000, 2'd0, 1'b1);
      step(); chk("to_regrant", 4'b0100, 2'd2, 1'b0);

      // Winner 2 withdraws; ptr becomes 3.
      req = 4'b0000;
      step(); chk("drop2", 4'b0000, 2'd0, 1'b0);
      req = 4'b0010;
      step(); chk("grant1_wrap", 4'b0010, 2'd1, 1'b0);
      req = 4'b1010;
      step(); chk("nonwinner_req", 4'b0010, 2'd1, 1'b0);
      req = 4'b1000;
      step(); chk("drop1", 4'b0000, 2'd0, 1'b0);
      req = 4'b1100;
      step(); chk("ptr2_after_drop", 4'b0100, 2'd2, 1'b0);

      // Ack in the same cycle as expiry counts as ack.
      for (int c = 2; c <= 8; c++) begin
         step(); chk($sformatf("sim_cycle%0d", c), 4'b0100, 2'd2, 1'b0);
      end
      ack = 4'b0100;
      step(); chk("ack_and_expiry", 4'b0000, 2'd0, 1'b0);
      ack = 4'b0000;

      // Reset while requester 3 holds the grant.
      step(); chk("grant3", 4'b1000, 2'd3, 1'b0);
      rst_an = 1'b0;
      ack    = 4'b1000;
      step(); chk("reset_mid_busy", 4'b0000, 2'd0, 1'b0);
      rst_an = 1'b1;
      ack    = 4'b0000;
      req    = 4'b1001;
      step(); chk("after_reset_ptr0", 4'b0001, 2'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
